// File: rtl/rat_pkg.sv
// ---------------------------------------------------------------------------
// rat_pkg
// Shared definitions for the RAT interrupt controller slice: the controller
// FSM state type and the default I/O port addresses it decodes on the CPU
// PORT_ID bus.
// ---------------------------------------------------------------------------
package rat_pkg;

    // IDLE   : waiting for an eligible pending source
    // ASSERT : INTERRUPT driven high, waiting for firmware ack
    // GUARD  : one dead cycle so RETIE retires before re-arbitration
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GUARD  = 2'd2
    } intr_state_t;

    localparam logic [7:0] DEF_ID_PORT   = 8'hF0;
    localparam logic [7:0] DEF_MASK_PORT = 8'hF1;
    localparam logic [7:0] DEF_PEND_PORT = 8'hF2;
    localparam logic [7:0] DEF_ACK_PORT  = 8'hF3;

endpackage

// File: rtl/rat_intr_ctrl_if.sv
// ---------------------------------------------------------------------------
// rat_intr_ctrl_if
// CPU I/O port bus as seen by a RAT peripheral.
//   PORT_ID  : port address driven by the CPU
//   OUT_PORT : write data driven by the CPU
//   IO_STRB  : one-cycle write strobe per OUTPUT instruction
//   IN_DATA  : peripheral read data for the IN_PORT mux
//   IN_HIT   : peripheral claims the current PORT_ID (mux select)
// master = CPU side, slave = peripheral side.
// ---------------------------------------------------------------------------
interface rat_intr_ctrl_if;

    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic       IO_STRB;
    logic [7:0] IN_DATA;
    logic       IN_HIT;

    modport master (
        output PORT_ID,
        output OUT_PORT,
        output IO_STRB,
        input  IN_DATA,
        input  IN_HIT
    );

    modport slave (
        input  PORT_ID,
        input  OUT_PORT,
        input  IO_STRB,
        output IN_DATA,
        output IN_HIT
    );

endinterface

// File: rtl/rat_sync_edge.sv
// ---------------------------------------------------------------------------
// rat_sync_edge
// N-bit synchronizer chain followed by a rising-edge detector.
//   i_clk    : clock
//   i_rst_n  : asynchronous active-low reset
//   i_async  : N request lines, possibly from another clock domain
//   o_rise   : one-cycle pulse per bit when the synchronized line goes 0->1
// STAGES = 0 bypasses the chain for sources already in the i_clk domain.
// ---------------------------------------------------------------------------
module rat_sync_edge #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_async,
    output logic [N-1:0] o_rise
);

    logic [N-1:0] w_synced;
    logic [N-1:0] r_prev;

    generate
        if (STAGES > 0) begin : g_sync
            logic [N-1:0] r_chain [STAGES];

            // Plain shift chain; only the last stage is used downstream.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int s = 0; s < STAGES; s++) begin
                        r_chain[s] <= '0;
                    end
                end else begin
                    r_chain[0] <= i_async;
                    for (int s = 1; s < STAGES; s++) begin
                        r_chain[s] <= r_chain[s-1];
                    end
                end
            end

            assign w_synced = r_chain[STAGES-1];
        end else begin : g_bypass
            assign w_synced = i_async;
        end
    endgenerate

    // Previous synchronized value, refreshed every cycle, so a line that is
    // held high yields exactly one rise pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_synced;
        end
    end

    assign o_rise = w_synced & ~r_prev;

endmodule

// File: rtl/rat_intr_ctrl.sv
// ---------------------------------------------------------------------------
// rat_intr_ctrl
// Multi-source interrupt controller for the RAT CPU. Latches request edges as
// pending, gates them with a software mask, picks the lowest-index eligible
// source and holds INTERRUPT high until firmware writes ACK_PORT.
//   CLK       : system clock
//   RESET_N   : asynchronous active-low reset
//   IRQ_SRC   : NUM_SRC level request lines (rising edge = one event)
//   bus       : CPU port bus (PORT_ID/OUT_PORT/IO_STRB in, IN_DATA/IN_HIT out)
//   INTERRUPT : registered interrupt request to the CPU
// Port map: ID_PORT (R) {in_service,4'b0,id}, MASK_PORT (R/W), PEND_PORT (R),
//           ACK_PORT (W, data ignored).
// ---------------------------------------------------------------------------
module rat_intr_ctrl
    import rat_pkg::*;
#(
    parameter int         NUM_SRC     = 8,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] ID_PORT     = DEF_ID_PORT,
    parameter logic [7:0] MASK_PORT   = DEF_MASK_PORT,
    parameter logic [7:0] PEND_PORT   = DEF_PEND_PORT,
    parameter logic [7:0] ACK_PORT    = DEF_ACK_PORT
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [NUM_SRC-1:0] IRQ_SRC,
    rat_intr_ctrl_if.slave     bus,
    output logic               INTERRUPT
);

    intr_state_t        r_state;
    intr_state_t        w_nextState;
    logic [NUM_SRC-1:0] r_pend;
    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_elig;
    logic [NUM_SRC-1:0] w_ackClr;
    logic [NUM_SRC-1:0] w_pendNext;
    logic [2:0]         r_activeId;
    logic [2:0]         w_winner;
    logic               r_interrupt;
    logic               w_ackStrb;
    logic               w_maskWr;
    logic [7:0]         w_maskExt;
    logic [7:0]         w_pendExt;

    rat_sync_edge #(
        .N      (NUM_SRC),
        .STAGES (SYNC_STAGES)
    ) u_syncEdge (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_async (IRQ_SRC),
        .o_rise  (w_rise)
    );

    assign w_ackStrb = bus.IO_STRB && (bus.PORT_ID == ACK_PORT);
    assign w_maskWr  = bus.IO_STRB && (bus.PORT_ID == MASK_PORT);
    assign w_elig    = r_pend & r_mask;

    // Fixed priority: scanning downward leaves the lowest set index.
    always_comb begin
        w_winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_winner = 3'(i);
            end
        end
    end

    // Only an ack while ASSERT clears anything; acks in IDLE/GUARD are dropped.
    // A rise in the same cycle is OR-ed in afterwards so the new event wins.
    always_comb begin
        w_ackClr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_ackClr[i] = (r_state == ASSERT) && w_ackStrb && (r_activeId == 3'(i));
        end
        w_pendNext = (r_pend & ~w_ackClr) | w_rise;
    end

    // Next-state logic. Masking the in-service source does not leave ASSERT;
    // only the ack does.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (|w_elig)   w_nextState = ASSERT;
            ASSERT:  if (w_ackStrb) w_nextState = GUARD;
            GUARD:                  w_nextState = IDLE;
            default:                w_nextState = IDLE;
        endcase
    end

    // State, in-service ID and the registered INTERRUPT. The ID is only
    // loaded when leaving IDLE, so it stays frozen through ASSERT and GUARD.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= IDLE;
            r_activeId  <= '0;
            r_interrupt <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_interrupt <= (w_nextState == ASSERT);
            if ((r_state == IDLE) && (|w_elig)) begin
                r_activeId <= w_winner;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pend <= '0;
            r_mask <= '0;
        end else begin
            r_pend <= w_pendNext;
            if (w_maskWr) begin
                r_mask <= bus.OUT_PORT[NUM_SRC-1:0];
            end
        end
    end

    assign INTERRUPT = r_interrupt;

    // Read mux; unused high bits of mask/pend read as zero.
    always_comb begin
        w_maskExt                = '0;
        w_pendExt                = '0;
        w_maskExt[NUM_SRC-1:0]   = r_mask;
        w_pendExt[NUM_SRC-1:0]   = r_pend;
        bus.IN_HIT               = 1'b0;
        bus.IN_DATA              = 8'h00;
        if (bus.PORT_ID == ID_PORT) begin
            bus.IN_HIT  = 1'b1;
            bus.IN_DATA = {(r_state == ASSERT), 4'b0000, r_activeId};
        end else if (bus.PORT_ID == MASK_PORT) begin
            bus.IN_HIT  = 1'b1;
            bus.IN_DATA = w_maskExt;
        end else if (bus.PORT_ID == PEND_PORT) begin
            bus.IN_HIT  = 1'b1;
            bus.IN_DATA = w_pendExt;
        end
    end

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rat_intr_ctrl
// Drives rat_intr_ctrl through directed scenarios and a randomized phase.
// Every cycle the expected INTERRUPT / IN_HIT / IN_DATA is predicted by an
// event-level model and queued; a monitor pops and compares independently.
// ---------------------------------------------------------------------------
module tb_rat_intr_ctrl;
    import rat_pkg::*;

    localparam int NUM_SRC     = 8;
    localparam int SYNC_STAGES = 2;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [7:0] IRQ_SRC;
    logic       INTERRUPT;
    logic [7:0] irqLevel;

    rat_intr_ctrl_if bus ();

    rat_intr_ctrl #(
        .NUM_SRC     (NUM_SRC),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .IRQ_SRC   (IRQ_SRC),
        .bus       (bus),
        .INTERRUPT (INTERRUPT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic       intr;
        logic       hit;
        logic [7:0] data;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: pending/mask sets, which source is being served, and
    // whether we are in the one-cycle dead time after an ack. A request edge
    // sampled at clock k becomes pending SYNC_STAGES clocks later.
    bit [7:0] mPend, mMask, mLastIrq;
    bit       mServing, mGuard;
    int       mId;
    bit [7:0] mRiseQ[$];

    function automatic void modelReset();
        mPend    = '0;
        mMask    = '0;
        mLastIrq = '0;
        mServing = 1'b0;
        mGuard   = 1'b0;
        mId      = 0;
        mRiseQ.delete();
        for (int i = 0; i < SYNC_STAGES; i++) mRiseQ.push_back(8'h00);
    endfunction

    function automatic void modelRead(input logic [7:0] port, output logic hit, output logic [7:0] data);
        hit  = 1'b1;
        data = 8'h00;
        if (port == DEF_ID_PORT)        data = {mServing, 4'b0000, 3'(mId)};
        else if (port == DEF_MASK_PORT) data = mMask;
        else if (port == DEF_PEND_PORT) data = mPend;
        else                            hit  = 1'b0;
    endfunction

    function automatic void modelClock(input logic [7:0] irq, input logic strb,
                                       input logic [7:0] port, input logic [7:0] data);
        bit [7:0] ev, applied, elig, clr;
        bit       ack;
        ev       = irq & ~mLastIrq;
        mLastIrq = irq;
        mRiseQ.push_back(ev);
        applied  = mRiseQ.pop_front();
        ack      = strb && (port == DEF_ACK_PORT);
        elig     = mPend & mMask;
        clr      = '0;
        if (mGuard) begin
            mGuard = 1'b0;
        end else if (mServing) begin
            if (ack) begin
                clr[mId] = 1'b1;
                mServing = 1'b0;
                mGuard   = 1'b1;
            end
        end else if (elig != 0) begin
            mId      = $clog2(elig & (~elig + 8'd1));
            mServing = 1'b1;
        end
        mPend = (mPend & ~clr) | applied;
        if (strb && (port == DEF_MASK_PORT)) mMask = data;
    endfunction

    // One bus cycle: drive at the falling edge, queue the prediction, then
    // advance the model across the rising edge.
    task automatic applyStimulus(input logic rst, input logic strb, input logic [7:0] port,
                                 input logic [7:0] data, input string name);
        exp_t e;
        @(negedge CLK);
        RESET_N      = rst;
        IRQ_SRC      = irqLevel;
        bus.IO_STRB  = strb;
        bus.PORT_ID  = port;
        bus.OUT_PORT = data;
        if (!rst) modelReset();
        e.name = name;
        e.intr = mServing;
        modelRead(port, e.hit, e.data);
        expQ.push_back(e);
        @(posedge CLK);
        if (rst) modelClock(irqLevel, strb, port, data);
        else     modelReset();
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (INTERRUPT !== e.intr || bus.IN_HIT !== e.hit || bus.IN_DATA !== e.data) begin
            errors++;
            $display("[TB] FAIL %s: got intr=%0b hit=%0b data=%02h, expected intr=%0b hit=%0b data=%02h",
                     e.name, INTERRUPT, bus.IN_HIT, bus.IN_DATA, e.intr, e.hit, e.data);
        end
    endtask

    // Monitor: compares shortly after each falling edge, once inputs settled.
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            while (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    task automatic idle(input int n, input logic [7:0] port, input string name);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, port, 8'h00, name);
    endtask

    task automatic writePort(input logic [7:0] port, input logic [7:0] data, input string name);
        applyStimulus(1'b1, 1'b1, port, data, name);
    endtask

    task automatic pulseIrq(input logic [7:0] bits, input string name);
        irqLevel = irqLevel | bits;
        applyStimulus(1'b1, 1'b0, DEF_ID_PORT, 8'h00, name);
        irqLevel = irqLevel & ~bits;
    endtask

    initial begin
        logic [7:0] ports [6];
        logic       strb;
        logic [7:0] port;

        irqLevel     = '0;
        RESET_N      = 1'b0;
        IRQ_SRC      = '0;
        bus.IO_STRB  = 1'b0;
        bus.PORT_ID  = 8'h00;
        bus.OUT_PORT = 8'h00;
        modelReset();
        $display("[TB] start");

        repeat (3) applyStimulus(1'b0, 1'b0, DEF_MASK_PORT, 8'h00, "reset_hold");
        idle(1, DEF_PEND_PORT, "reset_release_pend");

        // Single source with latency and ack
        writePort(DEF_MASK_PORT, 8'h08, "t2_mask_wr");
        pulseIrq(8'h08, "t2_irq");
        idle(4, DEF_ID_PORT, "t2_wait_id");
        writePort(DEF_ACK_PORT, 8'h5A, "t2_ack");
        idle(3, DEF_ID_PORT, "t2_after_ack");
        idle(1, DEF_PEND_PORT, "t2_pend");

        // Two sources together: lowest index first, then the other after GUARD
        writePort(DEF_MASK_PORT, 8'hFF, "t3_mask_wr");
        pulseIrq(8'h44, "t3_irq");
        idle(4, DEF_ID_PORT, "t3_first_id");
        writePort(DEF_ACK_PORT, 8'h00, "t3_ack1");
        idle(3, DEF_ID_PORT, "t3_second_id");
        writePort(DEF_ACK_PORT, 8'h00, "t3_ack2");
        idle(2, DEF_PEND_PORT, "t3_pend");

        // Masked pending source, released by a mask write
        writePort(DEF_MASK_PORT, 8'h00, "t4_mask_clr");
        pulseIrq(8'h02, "t4_irq");
        idle(4, DEF_PEND_PORT, "t4_pend_masked");
        writePort(DEF_MASK_PORT, 8'h02, "t4_mask_set");
        idle(3, DEF_ID_PORT, "t4_id");
        writePort(DEF_ACK_PORT, 8'h00, "t4_ack");
        idle(2, DEF_PEND_PORT, "t4_pend");

        // New edge on the in-service source lands on the ack cycle
        writePort(DEF_MASK_PORT, 8'h01, "t5_mask_wr");
        pulseIrq(8'h01, "t5_irq");
        idle(3, DEF_ID_PORT, "t5_id");
        pulseIrq(8'h01, "t5_irq_again");
        idle(1, DEF_PEND_PORT, "t5_pend");
        writePort(DEF_ACK_PORT, 8'h00, "t5_ack_collide");
        idle(4, DEF_ID_PORT, "t5_reassert");
        writePort(DEF_ACK_PORT, 8'h00, "t5_ack_final");
        idle(2, DEF_PEND_PORT, "t5_pend_final");

        // Reset in the middle of ASSERT
        writePort(DEF_MASK_PORT, 8'hFF, "t1_mask_wr");
        pulseIrq(8'h05, "t1_irq");
        idle(4, DEF_PEND_PORT, "t1_pend_before");
        applyStimulus(1'b0, 1'b0, DEF_PEND_PORT, 8'h00, "t1_reset_pend");
        applyStimulus(1'b0, 1'b0, DEF_ID_PORT, 8'h00, "t1_reset_id");
        idle(1, DEF_PEND_PORT, "t1_after_pend");
        idle(1, DEF_MASK_PORT, "t1_after_mask");
        idle(1, DEF_ID_PORT, "t1_after_id");

        // Bus decode: stray ack, write to read-only port, unmapped read
        writePort(DEF_ACK_PORT, 8'hFF, "t6_ack_idle");
        writePort(DEF_PEND_PORT, 8'hFF, "t6_pend_wr");
        writePort(DEF_ID_PORT, 8'hFF, "t6_id_wr");
        idle(1, 8'h10, "t6_unmapped");
        idle(1, DEF_PEND_PORT, "t6_pend");
        idle(1, DEF_ID_PORT, "t6_id");

        // Randomized traffic
        ports = '{DEF_ID_PORT, DEF_MASK_PORT, DEF_PEND_PORT, DEF_ACK_PORT, 8'h10, 8'hF4};
        for (int n = 0; n < 600; n++) begin
            irqLevel = irqLevel ^ 8'($urandom & $urandom & $urandom);
            port = ports[$urandom_range(0, 5)];
            strb = ($urandom_range(0, 3) == 0);
            if (mServing && ($urandom_range(0, 2) == 0)) begin
                port = DEF_ACK_PORT;
                strb = 1'b1;
            end
            if ($urandom_range(0, 249) == 0)
                applyStimulus(1'b0, 1'b0, port, 8'($urandom), "rand_reset");
            else
                applyStimulus(1'b1, strb, port, 8'($urandom), "rand");
        end

        irqLevel = '0;
        idle(2, DEF_PEND_PORT, "final");
        @(negedge CLK);
        #4;
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d unchecked entries, expected 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
